// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - sequential instruction fetch into a PC-tagged DEPTH-entry queue with redirect flush
`timescale 1ns/1ps
module fetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4)
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [ADDR_W-1:0]        PC,
  output logic                     mem_rd_enable,
  output logic [ADDR_W-1:0]        mem_rd_addr,
  input  logic                     mem_rd_ready,
  input  logic [INSTR_W-1:0]       mem_rd_data,
  output logic                     instr_valid,
  output logic [INSTR_W-1:0]       instr_data,
  output logic [ADDR_W-1:0]        instr_pc,
  input  logic                     instr_ready,
  input  logic                     redirect_valid,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic [$clog2(DEPTH):0]   q_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD} state_t;

  state_t             r_state;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_en;
  logic               r_valid;
  logic [INSTR_W-1:0] r_head_data;
  logic [ADDR_W-1:0]  r_head_pc;
  logic [CNT_W-1:0]   r_count;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [INSTR_W-1:0] r_mem_data [DEPTH];
  logic [ADDR_W-1:0]  r_mem_pc   [DEPTH];

  logic               w_pop;
  logic               w_push;
  logic [CNT_W-1:0]   w_cnt_after_pop;
  logic [CNT_W-1:0]   w_cnt_next;
  logic [PTR_W-1:0]   w_rd_next;
  logic               w_room_idle;
  logic               w_room_next;

  // Redirect cancels both the pop and any push in its cycle.
  assign w_pop           = r_valid & instr_ready & ~redirect_valid;
  assign w_push          = (r_state == S_WAIT) & mem_rd_ready & ~redirect_valid;
  assign w_cnt_after_pop = r_count - CNT_W'(w_pop);
  assign w_cnt_next      = w_cnt_after_pop + CNT_W'(w_push);
  assign w_rd_next       = r_rd_ptr + PTR_W'(w_pop);
  assign w_room_idle     = w_cnt_after_pop < CNT_W'(DEPTH);
  assign w_room_next     = (w_cnt_after_pop + CNT_W'(1)) < CNT_W'(DEPTH);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= mem_rd_data;
      r_mem_pc[r_wr_ptr]   <= r_addr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_en        <= 1'b0;
      r_addr      <= '0;
      r_valid     <= 1'b0;
      r_head_data <= '0;
      r_head_pc   <= '0;
      r_count     <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
    end else if (redirect_valid) begin
      r_pc     <= redirect_pc;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      case (r_state)
        // An in-flight read that completes now needs no DISCARD wait.
        S_WAIT, S_DISCARD: begin
          if (mem_rd_ready) begin
            r_en    <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_DISCARD;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end else begin
      r_count  <= w_cnt_next;
      r_valid  <= (w_cnt_next != '0);
      r_rd_ptr <= w_rd_next;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_cnt_next != '0) begin
        if (w_cnt_after_pop == '0) begin
          r_head_data <= mem_rd_data;
          r_head_pc   <= r_addr;
        end else begin
          r_head_data <= r_mem_data[w_rd_next];
          r_head_pc   <= r_mem_pc[w_rd_next];
        end
      end
      case (r_state)
        S_IDLE: begin
          if (w_room_idle) begin
            r_en    <= 1'b1;
            r_addr  <= r_pc;
            r_pc    <= r_pc + PC_STEP;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_rd_ready) begin
            if (w_room_next) begin
              r_addr <= r_pc;
              r_pc   <= r_pc + PC_STEP;
            end else begin
              r_en    <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        S_DISCARD: begin
          if (mem_rd_ready) begin
            r_en    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign PC            = r_pc;
  assign mem_rd_enable = r_en;
  assign mem_rd_addr   = r_addr;
  assign instr_valid   = r_valid;
  assign instr_data    = r_head_data;
  assign instr_pc      = r_head_pc;
  assign q_count       = r_count;
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - randomized and directed bench for fetch_queue against a PC-stream reference model
`timescale 1ns/1ps
module tb_fetch_queue;
  localparam int ADDR_W = 32;
  localparam int INSTR_W = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic               clk;
  logic               reset;
  logic [ADDR_W-1:0]  PC;
  logic               mem_rd_enable;
  logic [ADDR_W-1:0]  mem_rd_addr;
  logic               mem_rd_ready;
  logic [INSTR_W-1:0] mem_rd_data;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr_data;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_ready;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic [CNT_W-1:0]   q_count;

  fetch_queue #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH),
                .RESET_PC(32'h0), .PC_STEP(32'h4)) dut (
    .clk(clk), .reset(reset), .PC(PC),
    .mem_rd_enable(mem_rd_enable), .mem_rd_addr(mem_rd_addr),
    .mem_rd_ready(mem_rd_ready), .mem_rd_data(mem_rd_data),
    .instr_valid(instr_valid), .instr_data(instr_data), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .q_count(q_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int cyc, mem_lat, cur_lat, wcnt;
  bit iready, redir, new_req, popped;
  logic [31:0] rpc;
  logic [31:0] req_q[$];
  int          req_cyc[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_data[$];
  logic        p_en, p_rdy, p_valid, p_iready, p_redir;
  logic [31:0] p_addr, p_rpc, p_ipc, p_idata;

  // One clock: memory responder + inputs at negedge, pre-edge sample, post-edge sample.
  task automatic cycle();
    @(negedge clk);
    if (mem_rd_ready) wcnt = 0;
    mem_rd_ready = 1'b0;
    if (mem_rd_enable) begin
      if (wcnt == 0) cur_lat = (mem_lat == 0) ? int'($urandom_range(1, 4)) : mem_lat;
      wcnt++;
      if (wcnt >= cur_lat) begin
        mem_rd_ready = 1'b1;
        mem_rd_data  = mem_rd_addr + 32'h8000;
      end
    end else begin
      wcnt = 0;
    end
    instr_ready    = iready;
    redirect_valid = redir;
    redirect_pc    = rpc;
    #4;
    p_en = mem_rd_enable; p_rdy = mem_rd_ready; p_valid = instr_valid; p_iready = instr_ready;
    p_redir = redirect_valid; p_addr = mem_rd_addr; p_rpc = redirect_pc;
    p_ipc = instr_pc; p_idata = instr_data;
    @(posedge clk);
    #1;
    cyc++;
    new_req = mem_rd_enable && (!p_en || p_rdy);
    if (new_req) begin
      req_q.push_back(mem_rd_addr);
      req_cyc.push_back(cyc);
    end
    popped = p_valid && p_iready && !p_redir;
    if (popped) begin
      pop_pc.push_back(p_ipc);
      pop_data.push_back(p_idata);
    end
    redir = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    mem_rd_ready = 1'b0; mem_rd_data = '0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    iready = 1'b0; redir = 1'b0; rpc = '0; wcnt = 0; cur_lat = 1; mem_lat = 1; cyc = 0;
    req_q.delete(); req_cyc.delete(); pop_pc.delete(); pop_data.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    mem_rd_ready = 1'b0; mem_rd_data = '0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (PC !== 32'h0) begin errors++; $display("FAIL reset_PC got %h exp %h", PC, 32'h0); end
    checks++; if (mem_rd_enable !== 1'b0) begin errors++; $display("FAIL reset_en got %b exp 0", mem_rd_enable); end
    checks++; if (mem_rd_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", mem_rd_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
    checks++; if (instr_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", instr_data); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_ipc got %h exp 0", instr_pc); end
    checks++; if (q_count !== CNT_W'(0)) begin errors++; $display("FAIL reset_count got %0d exp 0", q_count); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    mem_lat = 1; iready = 1'b1;
    repeat (8) cycle();
    checks++;
    if (req_cyc.size() < 1 || req_cyc[0] != 1) begin
      errors++; $display("FAIL b2b_first_req_cycle got %0d exp 1", (req_cyc.size() > 0) ? req_cyc[0] : -1);
    end
    checks++;
    if (req_cyc.size() < 3 || req_cyc[1] - req_cyc[0] != 1 || req_cyc[2] - req_cyc[1] != 1) begin
      errors++; $display("FAIL b2b_spacing got %0d reqs not consecutive exp consecutive", req_cyc.size());
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (req_q.size() <= i || req_q[i] !== 32'(i * 4)) begin
        errors++; $display("FAIL b2b_req%0d got %h exp %h", i, (req_q.size() > i) ? req_q[i] : 32'hx, 32'(i * 4));
      end
      checks++;
      if (pop_pc.size() <= i || pop_pc[i] !== 32'(i * 4) || pop_data[i] !== 32'(i * 4 + 32'h8000)) begin
        errors++;
        $display("FAIL b2b_pop%0d got %h/%h exp %h/%h", i, (pop_pc.size() > i) ? pop_pc[i] : 32'hx,
                 (pop_data.size() > i) ? pop_data[i] : 32'hx, 32'(i * 4), 32'(i * 4 + 32'h8000));
      end
    end
  endtask

  task automatic test_full();
    do_reset();
    mem_lat = 1; iready = 1'b0;
    repeat (20) cycle();
    checks++; if (req_q.size() != 4) begin errors++; $display("FAIL full_nreq got %0d exp 4", req_q.size()); end
    checks++; if (req_q.size() < 4 || req_q[3] !== 32'hC) begin errors++; $display("FAIL full_last_req got %0d reqs exp 4th=0xC", req_q.size()); end
    checks++; if (q_count !== CNT_W'(4)) begin errors++; $display("FAIL full_count got %0d exp 4", q_count); end
    checks++; if (mem_rd_enable !== 1'b0) begin errors++; $display("FAIL full_en got %b exp 0", mem_rd_enable); end
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin errors++; $display("FAIL full_head got %b/%h exp 1/0", instr_valid, instr_pc); end
    iready = 1'b1;
    cycle();
    iready = 1'b0;
    repeat (8) cycle();
    checks++; if (pop_pc.size() != 1 || pop_pc[0] !== 32'h0) begin errors++; $display("FAIL full_pop got %0d pops exp 1 of 0x0", pop_pc.size()); end
    checks++; if (req_q.size() != 5 || req_q[4] !== 32'h10) begin errors++; $display("FAIL full_refill got %0d reqs exp 5 ending 0x10", req_q.size()); end
    checks++; if (q_count !== CNT_W'(4)) begin errors++; $display("FAIL full_refill_count got %0d exp 4", q_count); end
    checks++; if (instr_pc !== 32'h4) begin errors++; $display("FAIL full_new_head got %h exp 4", instr_pc); end
  endtask

  task automatic test_latency();
    do_reset();
    mem_lat = 5; iready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      checks++;
      if (mem_rd_enable !== 1'b1 || mem_rd_addr !== 32'h0 || req_q.size() != 1) begin
        errors++; $display("FAIL lat_hold%0d got en=%b addr=%h nreq=%0d exp 1/0/1", k, mem_rd_enable, mem_rd_addr, req_q.size());
      end
    end
    cycle();
    checks++; if (req_q.size() != 2 || req_q[1] !== 32'h4) begin errors++; $display("FAIL lat_next got %0d reqs exp 2 ending 0x4", req_q.size()); end
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr_data !== 32'h8000) begin
      errors++; $display("FAIL lat_head got %b/%h/%h exp 1/0/8000", instr_valid, instr_pc, instr_data);
    end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    mem_lat = 1; iready = 1'b0;
    for (int k = 0; k < 20 && req_q.size() < 3; k++) cycle();
    mem_lat = 6;
    checks++; if (req_q.size() != 3 || mem_rd_addr !== 32'h8) begin errors++; $display("FAIL rw_setup got %0d reqs addr %h exp 3/8", req_q.size(), mem_rd_addr); end
    checks++; if (q_count !== CNT_W'(2)) begin errors++; $display("FAIL rw_setup_count got %0d exp 2", q_count); end
    rpc = 32'h100; redir = 1'b1;
    cycle();
    checks++; if (instr_valid !== 1'b0 || q_count !== CNT_W'(0)) begin errors++; $display("FAIL rw_flush got %b/%0d exp 0/0", instr_valid, q_count); end
    checks++; if (PC !== 32'h100) begin errors++; $display("FAIL rw_pc got %h exp 100", PC); end
    checks++; if (mem_rd_enable !== 1'b1 || mem_rd_addr !== 32'h8) begin errors++; $display("FAIL rw_hold got %b/%h exp 1/8", mem_rd_enable, mem_rd_addr); end
    mem_lat = 1; iready = 1'b1;
    for (int k = 0; k < 20 && req_q.size() < 4; k++) begin
      cycle();
      if (req_q.size() < 4) begin
        checks++; if (q_count !== CNT_W'(0)) begin errors++; $display("FAIL rw_discard_count got %0d exp 0", q_count); end
      end
    end
    checks++; if (req_q.size() != 4 || req_q[3] !== 32'h100) begin errors++; $display("FAIL rw_restart got %0d reqs exp 4 ending 0x100", req_q.size()); end
    for (int k = 0; k < 20 && pop_pc.size() == 0; k++) cycle();
    checks++;
    if (pop_pc.size() < 1 || pop_pc[0] !== 32'h100 || pop_data[0] !== 32'h8100) begin
      errors++; $display("FAIL rw_first_pop got %0d pops exp 0x100/0x8100", pop_pc.size());
    end
  endtask

  task automatic test_redirect_ready_pop();
    do_reset();
    mem_lat = 1; iready = 1'b1;
    repeat (3) cycle();
    rpc = 32'h200; redir = 1'b1;
    cycle();
    checks++;
    if (p_en !== 1'b1 || p_rdy !== 1'b1 || p_valid !== 1'b1 || p_addr !== 32'h8 || p_ipc !== 32'h4) begin
      errors++; $display("FAIL rrp_setup got en%b rdy%b v%b addr%h ipc%h exp 1/1/1/8/4", p_en, p_rdy, p_valid, p_addr, p_ipc);
    end
    checks++; if (q_count !== CNT_W'(0) || instr_valid !== 1'b0) begin errors++; $display("FAIL rrp_flush got %0d/%b exp 0/0", q_count, instr_valid); end
    checks++; if (mem_rd_enable !== 1'b0 || PC !== 32'h200) begin errors++; $display("FAIL rrp_idle got en=%b pc=%h exp 0/200", mem_rd_enable, PC); end
    cycle();
    checks++; if (mem_rd_enable !== 1'b1 || mem_rd_addr !== 32'h200 || PC !== 32'h204) begin
      errors++; $display("FAIL rrp_restart got %b/%h/%h exp 1/200/204", mem_rd_enable, mem_rd_addr, PC);
    end
    for (int k = 0; k < 20 && pop_pc.size() < 2; k++) cycle();
    checks++;
    if (pop_pc.size() < 2 || pop_pc[1] !== 32'h200 || pop_data[1] !== 32'h8200) begin
      errors++; $display("FAIL rrp_pop got %0d pops exp 2nd 0x200/0x8200", pop_pc.size());
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    mem_lat = 5; iready = 1'b1;
    repeat (2) cycle();
    checks++; if (mem_rd_enable !== 1'b1 || mem_rd_addr !== 32'h0) begin errors++; $display("FAIL ar_setup got %b/%h exp 1/0", mem_rd_enable, mem_rd_addr); end
    @(negedge clk);
    #1;
    reset = 1'b0;
    mem_rd_ready = 1'b1;
    mem_rd_data = 32'hDEAD_BEEF;
    #1;
    checks++; if (mem_rd_enable !== 1'b0 || mem_rd_addr !== 32'h0) begin errors++; $display("FAIL ar_mem got %b/%h exp 0/0", mem_rd_enable, mem_rd_addr); end
    checks++; if (PC !== 32'h0 || q_count !== CNT_W'(0)) begin errors++; $display("FAIL ar_pc_count got %h/%0d exp 0/0", PC, q_count); end
    checks++; if (instr_valid !== 1'b0 || instr_data !== 32'h0 || instr_pc !== 32'h0) begin
      errors++; $display("FAIL ar_head got %b/%h/%h exp 0/0/0", instr_valid, instr_data, instr_pc);
    end
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (q_count !== CNT_W'(0) || instr_valid !== 1'b0) begin errors++; $display("FAIL ar_stray got %0d/%b exp 0/0", q_count, instr_valid); end
    checks++; if (mem_rd_enable !== 1'b1 || mem_rd_addr !== 32'h0 || PC !== 32'h4) begin
      errors++; $display("FAIL ar_restart got %b/%h/%h exp 1/0/4", mem_rd_enable, mem_rd_addr, PC);
    end
    mem_lat = 1;
    pop_pc.delete(); pop_data.delete();
    for (int k = 0; k < 20 && pop_pc.size() == 0; k++) cycle();
    checks++;
    if (pop_pc.size() < 1 || pop_pc[0] !== 32'h0 || pop_data[0] !== 32'h8000) begin
      errors++; $display("FAIL ar_first_pop got %0d pops exp 0x0/0x8000", pop_pc.size());
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, req_exp;
    int occ;
    bit tainted, acc;
    do_reset();
    mem_lat = 0;
    exp_pc = 32'h0; req_exp = 32'h0; occ = 0; tainted = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      iready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 24) == 0) begin
        redir = 1'b1;
        rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : $urandom;
      end
      cycle();
      acc = p_en && p_rdy;
      if (popped) begin
        checks++; if (p_ipc !== exp_pc) begin errors++; $display("FAIL rnd_pop_pc n=%0d got %h exp %h", n, p_ipc, exp_pc); end
        checks++; if (p_idata !== exp_pc + 32'h8000) begin errors++; $display("FAIL rnd_pop_data n=%0d got %h exp %h", n, p_idata, exp_pc + 32'h8000); end
        exp_pc = exp_pc + 32'h4;
      end
      if (p_redir) begin
        exp_pc = p_rpc; req_exp = p_rpc; occ = 0;
        tainted = p_en && !p_rdy;
      end else begin
        if (acc) begin
          if (!tainted) occ++;
          tainted = 1'b0;
        end
        if (popped) occ--;
      end
      if (new_req) begin
        checks++; if (mem_rd_addr !== req_exp) begin errors++; $display("FAIL rnd_req_addr n=%0d got %h exp %h", n, mem_rd_addr, req_exp); end
        checks++; if (occ >= DEPTH) begin errors++; $display("FAIL rnd_credit n=%0d got occ %0d exp <%0d", n, occ, DEPTH); end
        req_exp = req_exp + 32'h4;
      end
      if (p_en && !p_rdy) begin
        checks++;
        if (mem_rd_enable !== 1'b1 || mem_rd_addr !== p_addr) begin
          errors++; $display("FAIL rnd_hold n=%0d got %b/%h exp 1/%h", n, mem_rd_enable, mem_rd_addr, p_addr);
        end
      end
      checks++; if (PC !== req_exp) begin errors++; $display("FAIL rnd_PC n=%0d got %h exp %h", n, PC, req_exp); end
      checks++; if (q_count !== CNT_W'(occ)) begin errors++; $display("FAIL rnd_count n=%0d got %0d exp %0d", n, q_count, occ); end
      checks++; if (instr_valid !== (occ != 0)) begin errors++; $display("FAIL rnd_valid n=%0d got %b exp %b", n, instr_valid, occ != 0); end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_full();
    test_latency();
    test_redirect_wait();
    test_redirect_ready_pop();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
